exu_md_ctrl: RTL and testbench

Sequencing controller for the EXU multi-cycle multiply and divide units (exu_mul, exu_div).
- Accepts one M-extension op at a time from the EX stage with a valid/ready handshake.
- Latches the operands and holds the selected unit's valid level-high until that unit reports out_valid.
- Captures the result and presents it downstream with its own valid/ready handshake.
- Handles flush aborts.
- Keeps a one-entry div/rem pair cache, so a div followed by a rem (or the reverse) on identical operands skips the divider.

---
 rtl/exu_md_ctrl_pkg.sv | 14 +
 rtl/exu_md_cache.sv | 80 ++++++++
 rtl/exu_md_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_exu_md_ctrl.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_md_ctrl_pkg.sv
// Shared types and widths for the EXU multiply/divide sequencing controller.
package exu_md_ctrl_pkg;

  typedef enum logic [1:0] {
    EXU_MD_IDLE = 2'd0,
    EXU_MD_RUN  = 2'd1,
    EXU_MD_DONE = 2'd2
  } exu_md_state_e;

  localparam int EXU_MD_SIGNED_W = 2;
  localparam int EXU_MD_SEL_W    = 1;
  localparam int EXU_MD_WDOG_W   = 7;

endpackage

// File: rtl/exu_md_cache.sv
// One-entry div/rem pair cache: tag {signed, w, src1, src2} plus both results.
module exu_md_cache
  import exu_md_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [EXU_MD_SIGNED_W-1:0] wr_signed,
  input  logic                       wr_w,
  input  logic [XLEN-1:0]            wr_src1,
  input  logic [XLEN-1:0]            wr_src2,
  input  logic [XLEN-1:0]            wr_quot,
  input  logic [XLEN-1:0]            wr_rem,
  input  logic [EXU_MD_SIGNED_W-1:0] lk_signed,
  input  logic                       lk_w,
  input  logic [XLEN-1:0]            lk_src1,
  input  logic [XLEN-1:0]            lk_src2,
  output logic                       hit,
  output logic [XLEN-1:0]            rd_quot,
  output logic [XLEN-1:0]            rd_rem
);

  logic                       vld_q, vld_d;
  logic [EXU_MD_SIGNED_W-1:0] signed_q, signed_d;
  logic                       w_q, w_d;
  logic [XLEN-1:0]            src1_q, src1_d;
  logic [XLEN-1:0]            src2_q, src2_d;
  logic [XLEN-1:0]            quot_q, quot_d;
  logic [XLEN-1:0]            rem_q, rem_d;

  // Exact tag match against the incoming op; an empty entry never hits.
  assign hit = vld_q && (signed_q == lk_signed) && (w_q == lk_w) &&
               (src1_q == lk_src1) && (src2_q == lk_src2);
  assign rd_quot = quot_q;
  assign rd_rem  = rem_q;

  // Write port: a completed divide overwrites the single entry.
  always_comb begin
    vld_d    = vld_q;
    signed_d = signed_q;
    w_d      = w_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    if (wr_en) begin
      vld_d    = 1'b1;
      signed_d = wr_signed;
      w_d      = wr_w;
      src1_d   = wr_src1;
      src2_d   = wr_src2;
      quot_d   = wr_quot;
      rem_d    = wr_rem;
    end
  end

  // Entry storage; reset empties the cache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= 1'b0;
      signed_q <= '0;
      w_q      <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      vld_q    <= vld_d;
      signed_q <= signed_d;
      w_q      <= w_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

endmodule

// File: rtl/exu_md_ctrl.sv
// Sequencing controller for the multi-cycle multiply and divide units.
//
// state | meaning
// IDLE  | waiting for an op; in_ready while no flush
// RUN   | selected unit's valid held high until it returns out_valid
// DONE  | result presented on out_valid/out_result until out_ready
module exu_md_ctrl
  import exu_md_ctrl_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 127
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_is_div,
  input  logic [EXU_MD_SIGNED_W-1:0] in_signed,
  input  logic [EXU_MD_SEL_W-1:0]    in_sel,
  input  logic                       in_w,
  input  logic [XLEN-1:0]            in_src1,
  input  logic [XLEN-1:0]            in_src2,
  output logic                       mul_valid,
  output logic                       div_valid,
  output logic [EXU_MD_SIGNED_W-1:0] md_signed,
  output logic                       md_w,
  output logic [XLEN-1:0]            md_src1,
  output logic [XLEN-1:0]            md_src2,
  output logic                       md_flush,
  input  logic                       mul_out_valid,
  input  logic [XLEN-1:0]            mul_result_hi,
  input  logic [XLEN-1:0]            mul_result_lo,
  input  logic                       div_out_valid,
  input  logic [XLEN-1:0]            quotient,
  input  logic [XLEN-1:0]            remainder,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_result,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam logic [EXU_MD_WDOG_W-1:0] WDOG_MAX = EXU_MD_WDOG_W'(TIMEOUT);
  localparam logic [EXU_MD_WDOG_W-1:0] WDOG_PRE = EXU_MD_WDOG_W'(TIMEOUT - 1);

  exu_md_state_e              state_q, state_d;
  logic                       is_div_q, is_div_d;
  logic [EXU_MD_SEL_W-1:0]    sel_q, sel_d;
  logic [EXU_MD_SIGNED_W-1:0] signed_q, signed_d;
  logic                       w_q, w_d;
  logic [XLEN-1:0]            src1_q, src1_d;
  logic [XLEN-1:0]            src2_q, src2_d;
  logic                       mul_valid_q, mul_valid_d;
  logic                       div_valid_q, div_valid_d;
  logic                       out_valid_q, out_valid_d;
  logic [XLEN-1:0]            result_q, result_d;
  logic [EXU_MD_WDOG_W-1:0]   wdog_q, wdog_d;
  logic                       err_q, err_d;

  logic                       cache_hit;
  logic                       cache_wr;
  logic [XLEN-1:0]            cache_quot;
  logic [XLEN-1:0]            cache_rem;
  logic                       unit_done;

  // in_ready is also held low during reset so every output reads 0 then.
  assign in_ready    = (state_q == EXU_MD_IDLE) && !flush && !rst;
  assign md_flush    = flush;
  assign busy        = (state_q != EXU_MD_IDLE);
  assign mul_valid   = mul_valid_q;
  assign div_valid   = div_valid_q;
  assign md_signed   = signed_q;
  assign md_w        = w_q;
  assign md_src1     = src1_q;
  assign md_src2     = src2_q;
  assign out_valid   = out_valid_q;
  assign out_result  = result_q;
  assign err_timeout = err_q;

  // Only the unit this op was issued to may complete it.
  assign unit_done = is_div_q ? div_out_valid : mul_out_valid;

  exu_md_cache #(.XLEN(XLEN)) u_cache (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (cache_wr),
    .wr_signed (signed_q),
    .wr_w      (w_q),
    .wr_src1   (src1_q),
    .wr_src2   (src2_q),
    .wr_quot   (quotient),
    .wr_rem    (remainder),
    .lk_signed (in_signed),
    .lk_w      (in_w),
    .lk_src1   (in_src1),
    .lk_src2   (in_src2),
    .hit       (cache_hit),
    .rd_quot   (cache_quot),
    .rd_rem    (cache_rem)
  );

  // Next-state, latch, watchdog and registered-output logic.
  always_comb begin
    state_d     = state_q;
    is_div_d    = is_div_q;
    sel_d       = sel_q;
    signed_d    = signed_q;
    w_d         = w_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    mul_valid_d = mul_valid_q;
    div_valid_d = div_valid_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    wdog_d      = wdog_q;
    err_d       = 1'b0;
    cache_wr    = 1'b0;

    case (state_q)
      EXU_MD_IDLE: begin
        wdog_d = '0;
        if (in_valid && in_ready) begin
          is_div_d = in_is_div;
          sel_d    = in_sel;
          signed_d = in_signed;
          w_d      = in_w;
          src1_d   = in_src1;
          src2_d   = in_src2;
          if (in_is_div && cache_hit) begin
            state_d     = EXU_MD_DONE;
            out_valid_d = 1'b1;
            result_d    = in_sel[0] ? cache_quot : cache_rem;
          end else begin
            state_d     = EXU_MD_RUN;
            mul_valid_d = !in_is_div;
            div_valid_d = in_is_div;
          end
        end
      end

      EXU_MD_RUN: begin
        if (flush) begin
          state_d     = EXU_MD_IDLE;
          mul_valid_d = 1'b0;
          div_valid_d = 1'b0;
          wdog_d      = '0;
        end else if (unit_done) begin
          state_d     = EXU_MD_DONE;
          mul_valid_d = 1'b0;
          div_valid_d = 1'b0;
          out_valid_d = 1'b1;
          wdog_d      = '0;
          cache_wr    = is_div_q;
          if (is_div_q) begin
            result_d = sel_q[0] ? quotient : remainder;
          end else begin
            result_d = sel_q[0] ? mul_result_lo : mul_result_hi;
          end
        end else begin
          // Saturates so a stuck unit reports exactly once.
          if (wdog_q != WDOG_MAX) begin
            wdog_d = wdog_q + 1'b1;
          end
          err_d = (wdog_q == WDOG_PRE);
        end
      end

      EXU_MD_DONE: begin
        if (flush || out_ready) begin
          state_d     = EXU_MD_IDLE;
          out_valid_d = 1'b0;
        end
      end

      default: begin
        state_d     = EXU_MD_IDLE;
        mul_valid_d = 1'b0;
        div_valid_d = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EXU_MD_IDLE;
      is_div_q    <= 1'b0;
      sel_q       <= '0;
      signed_q    <= '0;
      w_q         <= 1'b0;
      src1_q      <= '0;
      src2_q      <= '0;
      mul_valid_q <= 1'b0;
      div_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_div_q    <= is_div_d;
      sel_q       <= sel_d;
      signed_q    <= signed_d;
      w_q         <= w_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      mul_valid_q <= mul_valid_d;
      div_valid_q <= div_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      wdog_q      <= wdog_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_exu_md_ctrl.sv
// Bench for exu_md_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model with stub mul/div units.
module tb_exu_md_ctrl;

  localparam int XLEN    = 64;
  localparam int TIMEOUT = 127;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush, in_valid, in_is_div, in_w, out_ready;
  logic [1:0]      in_signed;
  logic [0:0]      in_sel;
  logic [XLEN-1:0] in_src1, in_src2;
  logic            in_ready, mul_valid, div_valid, md_w, md_flush;
  logic [1:0]      md_signed;
  logic [XLEN-1:0] md_src1, md_src2;
  logic            mul_out_valid, div_out_valid;
  logic [XLEN-1:0] mul_result_hi, mul_result_lo, quotient, remainder;
  logic            out_valid, busy, err_timeout;
  logic [XLEN-1:0] out_result;

  exu_md_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_div(in_is_div), .in_signed(in_signed), .in_sel(in_sel), .in_w(in_w),
    .in_src1(in_src1), .in_src2(in_src2), .mul_valid(mul_valid), .div_valid(div_valid),
    .md_signed(md_signed), .md_w(md_w), .md_src1(md_src1), .md_src2(md_src2),
    .md_flush(md_flush), .mul_out_valid(mul_out_valid), .mul_result_hi(mul_result_hi),
    .mul_result_lo(mul_result_lo), .div_out_valid(div_out_valid), .quotient(quotient),
    .remainder(remainder), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference arithmetic for the stub units ----------------
  function automatic logic [63:0] sx32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic void ref_div(input logic [1:0] sg, input logic w,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] q, output logic [63:0] r);
    logic [63:0] aa, bb;
    logic signed [127:0] ea, eb, eq, er;
    aa = w ? (sg[1] ? sx32(a) : {32'd0, a[31:0]}) : a;
    bb = w ? (sg[1] ? sx32(b) : {32'd0, b[31:0]}) : b;
    if (bb == 64'd0) begin
      q = '1;
      r = aa;
    end else begin
      ea = sg[1] ? {{64{aa[63]}}, aa} : {64'd0, aa};
      eb = sg[1] ? {{64{bb[63]}}, bb} : {64'd0, bb};
      eq = ea / eb;
      er = ea % eb;
      q = eq[63:0];
      r = er[63:0];
    end
    if (w) begin
      q = sx32(q);
      r = sx32(r);
    end
  endfunction

  function automatic void ref_mul(input logic [1:0] sg, input logic w,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] hi, output logic [63:0] lo);
    logic signed [127:0] ea, eb, p;
    ea = sg[1] ? {{64{a[63]}}, a} : {64'd0, a};
    eb = sg[0] ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    lo = w ? sx32(p[63:0]) : p[63:0];
    hi = p[127:64];
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        is_div;
    logic [1:0]  sg;
    logic        sel;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
  } op_t;

  op_t         m_op;
  bit          m_wait, m_hold, m_err;
  logic [63:0] m_res;
  int          m_run;
  bit          c_vld;
  logic [1:0]  c_sg;
  logic        c_w;
  logic [63:0] c_a, c_b, c_q, c_r;

  task automatic model_reset();
    m_op = '0; m_wait = 0; m_hold = 0; m_err = 0; m_res = '0; m_run = 0;
    c_vld = 0; c_sg = '0; c_w = 0; c_a = '0; c_b = '0; c_q = '0; c_r = '0;
  endtask

  // What the controller must do on one clock edge, given the inputs present.
  task automatic model_step();
    bit err;
    err = 0;
    if (rst) begin
      model_reset();
    end else begin
      if (m_hold) begin
        if (flush || out_ready) m_hold = 0;
      end else if (m_wait) begin
        if (flush) begin
          m_wait = 0;
        end else if (m_op.is_div ? div_out_valid : mul_out_valid) begin
          if (m_op.is_div) begin
            m_res = m_op.sel ? quotient : remainder;
            c_vld = 1; c_sg = m_op.sg; c_w = m_op.w; c_a = m_op.a; c_b = m_op.b;
            c_q = quotient; c_r = remainder;
          end else begin
            m_res = m_op.sel ? mul_result_lo : mul_result_hi;
          end
          m_wait = 0;
          m_hold = 1;
        end else begin
          m_run++;
          err = (m_run == TIMEOUT);
        end
      end else if (in_valid && !flush) begin
        m_op = '{is_div: in_is_div, sg: in_signed, sel: in_sel[0], w: in_w,
                 a: in_src1, b: in_src2};
        if (in_is_div && c_vld && c_sg == in_signed && c_w == in_w &&
            c_a == in_src1 && c_b == in_src2) begin
          m_res  = in_sel[0] ? c_q : c_r;
          m_hold = 1;
        end else begin
          m_wait = 1;
          m_run  = 0;
        end
      end
      m_err = err;
    end
  endtask

  // ---------------- stub units ----------------
  int forced_lat = -1;
  int lat_cnt = 0;
  bit prev_wait = 0;

  task automatic stub_update();
    logic [63:0] h, l, q, r;
    mul_out_valid = 0;
    div_out_valid = 0;
    mul_result_hi = {$urandom, $urandom};
    mul_result_lo = {$urandom, $urandom};
    quotient      = {$urandom, $urandom};
    remainder     = {$urandom, $urandom};
    if (m_wait) begin
      if (!prev_wait) lat_cnt = (forced_lat >= 0) ? forced_lat : int'($urandom_range(0, 5));
      if (lat_cnt == 0) begin
        if (m_op.is_div) begin
          ref_div(m_op.sg, m_op.w, m_op.a, m_op.b, q, r);
          quotient = q; remainder = r; div_out_valid = 1;
        end else begin
          ref_mul(m_op.sg, m_op.w, m_op.a, m_op.b, h, l);
          mul_result_hi = h; mul_result_lo = l; mul_out_valid = 1;
        end
      end else begin
        lat_cnt--;
      end
    end
    // Stray completions from the wrong unit or outside RUN must be ignored.
    if ($urandom_range(0, 7) == 0) begin
      if (m_wait) begin
        if (m_op.is_div) mul_out_valid = 1;
        else             div_out_valid = 1;
      end else if ($urandom_range(0, 1) == 0) begin
        mul_out_valid = 1;
      end else begin
        div_out_valid = 1;
      end
    end
    prev_wait = m_wait;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    stub_update();
  endtask

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("in_ready", in_ready, !m_wait && !m_hold && !flush && !rst);
      chk("mul_valid", mul_valid, m_wait && !m_op.is_div);
      chk("div_valid", div_valid, m_wait && m_op.is_div);
      chk("out_valid", out_valid, m_hold);
      chk("out_result", out_result, m_res);
      chk("busy", busy, m_wait || m_hold);
      chk("err_timeout", err_timeout, m_err);
      chk("md_flush", md_flush, flush);
      chk("md_signed", md_signed, m_op.sg);
      chk("md_w", md_w, m_op.w);
      chk("md_src1", md_src1, m_op.a);
      chk("md_src2", md_src2, m_op.b);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic issue(input logic d, input logic [1:0] sg, input logic sel,
                       input logic w, input logic [63:0] a, input logic [63:0] b);
    in_is_div = d; in_signed = sg; in_sel = sel; in_w = w;
    in_src1 = a; in_src2 = b; in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
    end
    chk("wait_out_valid", out_valid, 1'b1);
  endtask

  task automatic release_out();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  logic [63:0] pool [6];
  logic [1:0]  last_sg;
  logic        last_w;
  logic [63:0] last_a, last_b;

  initial begin
    int n, pulses, pos;
    bit busy_ok;
    rst = 1; flush = 0; in_valid = 0; in_is_div = 0; in_signed = 0; in_sel = 0;
    in_w = 0; in_src1 = 0; in_src2 = 0; out_ready = 0;
    mul_out_valid = 0; div_out_valid = 0;
    mul_result_hi = 0; mul_result_lo = 0; quotient = 0; remainder = 0;
    model_reset();
    tick();
    tick();
    chk_on = 1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    rst = 0;
    tick();
    chk("idle_in_ready", in_ready, 1'b1);

    // Signed mul low half: -3 * 5, unit answers in its 4th RUN cycle.
    forced_lat = 3;
    issue(1'b0, 2'b11, 1'b1, 1'b0, -64'sd3, 64'd5);
    busy_ok = busy;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
      if (!busy) busy_ok = 0;
    end
    chk("mul_busy", busy_ok, 1'b1);
    chk("mul_latency", n, 4);
    chk("mul_result", out_result, 64'hFFFF_FFFF_FFFF_FFF1);
    release_out();
    forced_lat = -1;

    // Div 100/7 then rem on the same operands.
    issue(1'b1, 2'b11, 1'b1, 1'b0, 64'd100, 64'd7);
    wait_out(n);
    chk("div_q", out_result, 64'd14);
    release_out();
    issue(1'b1, 2'b11, 1'b0, 1'b0, 64'd100, 64'd7);
    chk("hit_out_valid", out_valid, 1'b1);
    chk("hit_div_valid", div_valid, 1'b0);
    chk("hit_rem", out_result, 64'd2);
    release_out();

    // Same operands, different w / signedness must miss.
    issue(1'b1, 2'b11, 1'b0, 1'b1, 64'd100, 64'd7);
    chk("miss_w_div_valid", div_valid, 1'b1);
    wait_out(n);
    chk("miss_w_rem", out_result, 64'd2);
    release_out();
    issue(1'b1, 2'b00, 1'b1, 1'b0, 64'd100, 64'd7);
    chk("miss_sg_div_valid", div_valid, 1'b1);
    wait_out(n);
    chk("miss_sg_q", out_result, 64'd14);
    release_out();

    // Flush two cycles into a divide.
    forced_lat = 10;
    issue(1'b1, 2'b11, 1'b1, 1'b0, 64'd200, 64'd7);
    tick();
    flush = 1;
    #1;
    chk("flush_md_flush", md_flush, 1'b1);
    tick();
    flush = 0;
    chk("flush_div_valid", div_valid, 1'b0);
    chk("flush_busy", busy, 1'b0);
    chk("flush_out_valid", out_valid, 1'b0);
    forced_lat = -1;
    issue(1'b1, 2'b11, 1'b1, 1'b0, 64'd200, 64'd7);
    chk("flush_no_cache", div_valid, 1'b1);

    // Backpressure: result held, nothing accepted, release returns to idle.
    wait_out(n);
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_result", out_result, 64'd28);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    release_out();
    chk("bp_released_busy", busy, 1'b0);
    chk("bp_released_valid", out_valid, 1'b0);
    in_valid = 0;

    // Asynchronous reset between edges while a divide runs.
    forced_lat = 50;
    issue(1'b1, 2'b11, 1'b1, 1'b0, 64'd1000, 64'd3);
    tick();
    tick();
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("arst_div_valid", div_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_md_src1", md_src1, 64'd0);
    chk("arst_in_ready", in_ready, 1'b0);
    tick();
    tick();
    rst = 0;
    forced_lat = -1;
    tick();
    issue(1'b1, 2'b11, 1'b1, 1'b0, 64'd200, 64'd7);
    chk("arst_cache_cleared", div_valid, 1'b1);
    wait_out(n);
    chk("arst_q", out_result, 64'd28);
    release_out();

    // Watchdog: unit silent for 130 cycles.
    forced_lat = 130;
    issue(1'b0, 2'b00, 1'b0, 1'b0, 64'd12345, 64'd678);
    pulses = 0;
    pos = -1;
    n = 0;
    while (!out_valid && n < 300) begin
      tick();
      n++;
      if (err_timeout) begin
        pulses++;
        if (pos < 0) pos = n;
      end
    end
    chk("wdog_pulses", pulses, 1);
    chk("wdog_pos", pos, TIMEOUT);
    release_out();
    forced_lat = -1;

    // Randomized traffic.
    pool[0] = 64'd100; pool[1] = 64'd7; pool[2] = 64'hFFFF_FFFF_FFFF_FFFD;
    pool[3] = 64'h8000_0000_0000_0000; pool[4] = 64'd0; pool[5] = '1;
    last_sg = 2'b11; last_w = 0; last_a = 64'd9; last_b = 64'd4;
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 4) < 3);
      in_is_div = ($urandom_range(0, 2) != 0);
      in_sel    = 1'($urandom_range(0, 1));
      if (in_is_div && $urandom_range(0, 4) < 2) begin
        in_signed = last_sg; in_w = last_w; in_src1 = last_a; in_src2 = last_b;
      end else begin
        in_signed = 2'($urandom_range(0, 3));
        in_w      = 1'($urandom_range(0, 1));
        in_src1   = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : pool[$urandom_range(0, 5)];
        in_src2   = ($urandom_range(0, 4) == 0) ? {$urandom, $urandom} : pool[$urandom_range(0, 5)];
      end
      if (in_is_div) begin
        last_sg = in_signed; last_w = in_w; last_a = in_src1; last_b = in_src2;
      end
      tick();
    end
    in_valid = 0;
    flush = 0;
    out_ready = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("drain_idle", busy, 1'b0);

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
